// File: rtl/wb_arbiter.sv
// Two-requester register-file write arbiter with round-robin priority on contention,
// a registered write port, and a 32-entry pending-write scoreboard for issue.
module wb_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  input  logic        issue_set,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_q,
  input  logic [4:0]  rs2_q,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  a3,
  output logic        we3,
  output logic [31:0] wd3
);

  logic        prio;
  logic [31:0] pend, pend_nxt;
  logic        contend, grant0, grant1;
  logic [4:0]  g_rd;
  logic [31:0] g_data;

  // Ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    contend = req0_valid & req1_valid;
    grant0  = ~rst & req0_valid & (~req1_valid | ~prio);
    grant1  = ~rst & req1_valid & (~req0_valid |  prio);
    g_rd    = grant1 ? req1_rd   : req0_rd;
    g_data  = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3  <= 1'b0;
      a3   <= '0;
      wd3  <= '0;
      prio <= RR_INIT;
    end else begin
      if (grant0 | grant1) begin
        a3  <= g_rd;
        wd3 <= g_data;
        we3 <= |g_rd;   // x0 writes are accepted but never reach the file
      end else begin
        we3 <= 1'b0;
      end
      if (contend) prio <= ~prio;
    end
  end

  // Clear on write, then set on issue, so a same-cycle set wins.
  always_comb begin
    pend_nxt = pend;
    if (we3) pend_nxt[a3] = 1'b0;
    if (issue_set) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  // A register being written this cycle reads as free so issue can proceed next cycle.
  assign rs1_busy = pend[rs1_q] & ~(we3 && (a3 == rs1_q));
  assign rs2_busy = pend[rs2_q] & ~(we3 && (a3 == rs2_q));

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: a cycle-level behavioural model of grants, the
// write port and the pending set, plus directed scenarios with literal expectations.
module tb_wb_arbiter;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_rd, req1_rd, issue_rd, rs1_q, rs2_q, a3;
  logic [31:0] req0_data, req1_data, wd3;
  logic        issue_set, rs1_busy, rs2_busy, we3;

  wb_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_set(issue_set), .issue_rd(issue_rd), .rs1_q(rs1_q), .rs2_q(rs2_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .a3(a3), .we3(we3), .wd3(wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, illegal_issues = 0;

  // Model state: who has priority, which registers await a write, what the port shows.
  bit        m_prio;
  bit [31:0] m_pend;
  bit        m_we;
  bit [4:0]  m_a3;
  bit [31:0] m_wd;
  bit        last_g0, last_g1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exp_g0();
    return !rst && req0_valid && (!req1_valid || !m_prio);
  endfunction

  function automatic bit exp_g1();
    return !rst && req1_valid && (!req0_valid || m_prio);
  endfunction

  function automatic bit exp_busy(input bit [4:0] q);
    return m_pend[q] && !(m_we && m_a3 == q);
  endfunction

  task automatic model_reset();
    m_prio = 1'b0; m_pend = '0; m_we = 0; m_a3 = '0; m_wd = '0;
    last_g0 = 0; last_g1 = 0;
  endtask

  // Advance the model across one rising edge using the inputs held through it.
  task automatic tick();
    bit g0, g1;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      g0 = exp_g0(); g1 = exp_g1();
      last_g0 = g0; last_g1 = g1;
      if (issue_set && issue_rd != 0 && m_pend[issue_rd] && !(m_we && m_a3 == issue_rd)) begin
        illegal_issues++;
        $display("WARN illegal WAW issue to x%0d at %0t", issue_rd, $time);
      end
      if (m_we) m_pend[m_a3] = 1'b0;
      if (issue_set && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (g0 || g1) begin
        m_a3 = g0 ? req0_rd : req1_rd;
        m_wd = g0 ? req0_data : req1_data;
        m_we = (m_a3 != 0);
        if (req0_valid && req1_valid) m_prio = ~m_prio;
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    tick();
    @(negedge clk);
  endtask

  task automatic cmp_all();
    chk("req0_ready", req0_ready, exp_g0());
    chk("req1_ready", req1_ready, exp_g1());
    chk("we3", we3, m_we);
    chk("a3", a3, m_a3);
    chk("wd3", wd3, m_wd);
    chk("rs1_busy", rs1_busy, exp_busy(rs1_q));
    chk("rs2_busy", rs2_busy, exp_busy(rs2_q));
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; issue_set = 0;
  endtask

  initial begin
    rst = 0; idle();
    req0_rd = 0; req1_rd = 0; req0_data = 0; req1_data = 0;
    issue_rd = 0; rs1_q = 0; rs2_q = 0;
    model_reset();
    #2 rst = 1;
    cycle(); cycle();
    #1 chk("reset_we3", we3, 0);
    chk("reset_a3", a3, 0);
    chk("reset_wd3", wd3, 0);
    chk("reset_ready0", req0_ready, 0);
    rst = 0;
    #1 cmp_all();

    // Contention from RR_INIT=0: grants alternate 0,1,0,1.
    req0_valid = 1; req0_rd = 1; req0_data = 32'h1111_1111;
    req1_valid = 1; req1_rd = 2; req1_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1 cmp_all();
      chk("cont_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
      cycle();
      if (i == 3) idle();
      #1 cmp_all();
      chk("cont_a3", a3, (i % 2 == 0) ? 1 : 2);
      chk("cont_we3", we3, 1);
    end

    // Lone request with 1-cycle write latency.
    cycle();
    req0_valid = 1; req0_rd = 5; req0_data = 32'hDEAD_BEEF;
    #1 cmp_all();
    chk("lone_ready0", req0_ready, 1);
    cycle(); idle();
    #1 cmp_all();
    chk("lone_we3", we3, 1);
    chk("lone_a3", a3, 5);
    chk("lone_wd3", wd3, 32'hDEAD_BEEF);
    cycle();
    #1 cmp_all();
    chk("lone_we3_drop", we3, 0);

    // x0 write is accepted but suppressed.
    req1_valid = 1; req1_rd = 0; req1_data = 32'h0BAD_F00D; rs1_q = 0;
    #1 cmp_all();
    chk("x0_ready1", req1_ready, 1);
    chk("x0_busy", rs1_busy, 0);
    cycle(); idle();
    #1 cmp_all();
    chk("x0_we3", we3, 0);
    chk("x0_busy_after", rs1_busy, 0);

    // Scoreboard lifecycle on x7.
    issue_set = 1; issue_rd = 7; rs1_q = 7;
    #1 cmp_all();
    chk("sb_busy_before", rs1_busy, 0);
    cycle(); issue_set = 0;
    #1 cmp_all();
    chk("sb_busy_set", rs1_busy, 1);
    cycle();
    req1_valid = 1; req1_rd = 7; req1_data = 32'h7777_0007;
    #1 cmp_all();
    chk("sb_busy_req", rs1_busy, 1);
    cycle(); idle();
    #1 cmp_all();
    chk("sb_we3", we3, 1);
    chk("sb_busy_wr", rs1_busy, 0);
    cycle();
    #1 cmp_all();
    chk("sb_busy_clr", rs1_busy, 0);
    // Re-issue x7, then set it again in the very cycle it is written back.
    issue_set = 1; issue_rd = 7;
    cycle(); issue_set = 0;
    req1_valid = 1; req1_rd = 7; req1_data = 32'h7777_0017;
    cycle(); idle();
    issue_set = 1; issue_rd = 7;
    #1 cmp_all();
    chk("sb_same_we3", we3, 1);
    cycle(); issue_set = 0;
    #1 cmp_all();
    chk("sb_same_busy", rs1_busy, 1);
    req1_valid = 1; req1_rd = 7;
    cycle(); idle();
    cycle();
    #1 cmp_all();

    // Reset mid-operation: a grant is pending when rst asserts.
    req0_valid = 1; req0_rd = 4; req1_valid = 1; req1_rd = 5;
    issue_set = 1; issue_rd = 3; rs2_q = 3;
    cycle(); idle();                     // contended: priority now with requester 1
    req0_valid = 1; req0_rd = 9; req0_data = 32'h9999_9999;
    #1 cmp_all();
    chk("rstmid_busy3", rs2_busy, 1);
    chk("rstmid_ready0", req0_ready, 1);
    rst = 1; model_reset();
    #1 cmp_all();
    chk("rstmid_ready_gated", req0_ready, 0);
    chk("rstmid_we3", we3, 0);
    req0_valid = 0;
    cycle();
    rst = 0;
    #1 cmp_all();
    chk("rstmid_busy_clr", rs2_busy, 0);
    chk("rstmid_we3_after", we3, 0);
    req0_valid = 1; req0_rd = 6; req1_valid = 1; req1_rd = 8;
    #1 cmp_all();
    chk("rstmid_prio", req0_ready, 1);
    cycle(); idle();
    #1 cmp_all();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (rst) begin
        rst = 0; req0_valid = 0; req1_valid = 0;
      end else begin
        if (!(req0_valid && !last_g0)) begin
          req0_valid = ($urandom_range(0, 99) < 55);
          req0_rd    = 5'($urandom_range(0, 7));
          req0_data  = $urandom;
        end
        if (!(req1_valid && !last_g1)) begin
          req1_valid = ($urandom_range(0, 99) < 55);
          req1_rd    = 5'($urandom_range(0, 7));
          req1_data  = $urandom;
        end
      end
      issue_rd  = 5'($urandom_range(0, 7));
      issue_set = ($urandom_range(0, 99) < 35) &&
                  (!m_pend[issue_rd] || (m_we && m_a3 == issue_rd));
      rs1_q = 5'($urandom_range(0, 7));
      rs2_q = 5'($urandom_range(0, 7));
      #1 cmp_all();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; model_reset();
        #1 cmp_all();
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, requester given priority after reset (0 or 1).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 (ALU writeback) has a write
- req0_ready  out  1  requester 0 write accepted this cycle
- req0_rd  in  5  requester 0 destination register
- req0_data  in  32  requester 0 write data
- req1_valid, req1_ready, req1_rd, req1_data  same as requester 0, for requester 1 (LSU / multi-cycle unit)
- issue_set  in  1  issue stage marks a destination register pending
- issue_rd  in  5  register to mark pending
- rs1_q, rs2_q  in  5 each  source registers queried by issue
- rs1_busy, rs2_busy  out  1 each  queried register has a pending write
- a3  out  5  register file write address
- we3  out  1  register file write enable
- wd3  out  32  register file write data

Function
REQ-003 The block SHALL grant at most one requester per cycle; reqN_ready is high exactly in the cycle requester N is granted, combinationally from valid and priority.
REQ-004 With a single valid requester, that requester SHALL be granted that cycle.
REQ-005 With both requesters valid, the block SHALL grant the requester holding priority; priority then passes to the other requester at the clock edge.
REQ-006 Priority SHALL change only on a contended grant. A lone grant leaves priority unchanged.
REQ-007 A requester SHALL hold valid, rd and data stable until it sees ready. The arbiter does not buffer ungranted requests.
REQ-008 A granted request SHALL be registered: a3/wd3 take the request's rd/data and we3=1 on the next edge, so the write port has 1-cycle latency.
REQ-009 we3 SHALL be low in any cycle following a cycle with no grant; a3/wd3 hold their last values.
REQ-010 A granted request with rd=0 SHALL be accepted (ready=1) but produce we3=0.
REQ-011 The scoreboard SHALL hold 32 pending bits. Bit 0 is hard-wired 0.
REQ-012 A pending bit SHALL be set at the edge where issue_set=1 and issue_rd≠0.
REQ-013 A pending bit SHALL be cleared at the edge where we3=1 and a3 addresses it, coinciding with the register file write.
REQ-014 If set and clear target the same register in the same cycle, the bit SHALL end set.
REQ-015 rsN_busy SHALL equal the current pending bit of rsN_q, combinationally.
REQ-016 rsN_busy SHALL be 0 in the cycle the register is being written (we3=1, a3=rsN_q), so issue may read the value on the following cycle.
REQ-017 issue_set to an already-pending register is illegal (WAW stalls upstream). The bench SHALL flag it; RTL behaviour is to keep the bit set.

Reset
REQ-018 While rst=1: we3=0, a3=0, wd3=0, all pending bits 0, priority=RR_INIT.
REQ-019 reqN_ready SHALL be 0 while rst=1 and after asynchronous assertion.
REQ-020 A grant in flight when reset asserts SHALL be discarded: no write, no scoreboard clear.
REQ-021 Normal operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-022 Lone request: req0 valid, rd=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle we3=1, a3=5, wd3=0xDEADBEEF; cycle after, we3=0.
REQ-023 Contention, RR_INIT=0, both requesters held valid for 4 cycles (rd 1 and 2) -> grants 0,1,0,1; a3 sequence 1,2,1,2 each one cycle later.
REQ-024 x0 write: req1 valid, rd=0 -> req1_ready=1, we3 stays 0; rs1_q=0 -> rs1_busy=0 throughout.
REQ-025 Scoreboard lifecycle: issue_set rd=7; later req1 writes rd=7 -> rs1_busy(7)=1 from edge after set until we3 cycle, then 0. Set and clear of 7 in same cycle -> busy stays 1.
REQ-026 Reset mid-operation: grant issued, rst asserted before the next edge -> we3 never rises, pending bits all 0, priority=RR_INIT after release.
